// File: rtl/cram_store_if.sv
// Interface bundling the CRAM read-address, diagnostic-write and status signals of cram_store.
// Ports: cradr, ebus_data, wr_00_19..wr_60_79 and par_clr flow from master to slave.
//        cram, busy, par_err and par_err_slice flow back from slave to master.
interface cram_store_if;
    logic [0:10] cradr;
    logic [0:19] ebus_data;
    logic        wr_00_19;
    logic        wr_20_39;
    logic        wr_40_59;
    logic        wr_60_79;
    logic        par_clr;
    logic [0:79] cram;
    logic        busy;
    logic        par_err;
    logic [0:3]  par_err_slice;

    modport master (
        output cradr, ebus_data, wr_00_19, wr_20_39, wr_40_59, wr_60_79, par_clr,
        input  cram, busy, par_err, par_err_slice
    );

    modport slave (
        input  cradr, ebus_data, wr_00_19, wr_20_39, wr_40_59, wr_60_79, par_clr,
        output cram, busy, par_err, par_err_slice
    );
endinterface

// File: rtl/cram_store.sv
// CRAM control store: 2048 x (80 data + 4 odd-parity) words with a registered read port,
// a two-cycle slice-wise diagnostic write path (capture, then commit) and sticky parity checking.
// Ports: clk, RESET (sync, active-high), bus (cram_store_if.slave) carrying cradr/ebus_data/
//        slice strobes/par_clr in and cram/busy/par_err/par_err_slice out.
// Latency: cram is mem[cradr] one edge later; parity flags follow the load by one more edge.
// Backpressure: none; back-to-back captures are pipelined and never dropped.
module cram_store (
    input  logic        clk,
    input  logic        RESET,
    cram_store_if.slave bus
);
    localparam int SLICES = 4;
    localparam int SW     = 20;

    // Storage. Every word starts as all-zero data with all parity bits set, which is
    // the odd-parity encoding of a zero slice. RESET never touches these arrays.
    logic [0:79] mem_data [0:2047] = '{default: '0};
    logic [0:3]  mem_par  [0:2047] = '{default: 4'b1111};

    // Slice strobes in slice order: index 0 = bits 0:19 ... index 3 = bits 60:79.
    logic [0:3]  strb;
    logic        ebus_par;

    // Staging word filled in the capture cycle and written in the following commit cycle.
    logic [0:79] stage_data;
    logic [0:3]  stage_par;
    logic [0:10] cm_addr;
    logic [0:3]  cm_mask;
    logic        cm_vld;

    logic [0:79] rd_data;
    logic [0:3]  rd_par;

    logic [0:79] cram_q;
    logic [0:3]  cram_par;
    logic        chk_en;
    logic [0:3]  err_vec;
    logic [0:3]  err_q;
    logic [0:3]  err_nxt;

    assign strb     = {bus.wr_00_19, bus.wr_20_39, bus.wr_40_59, bus.wr_60_79};
    assign ebus_par = ~^bus.ebus_data;

    // Capture: every strobed slice receives the same EBUS data and its odd parity.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            for (int s = 0; s < SLICES; s++) begin
                if (strb[s]) begin
                    stage_data[s*SW +: SW] <= bus.ebus_data;
                    stage_par[s]           <= ebus_par;
                end
            end
        end
    end

    // Commit bookkeeping. A capture in the commit cycle simply loads the next commit,
    // so back-to-back strobes keep cm_vld (and busy) high with nothing lost.
    always_ff @(posedge clk) begin
        if (RESET) begin
            cm_vld  <= 1'b0;
            cm_mask <= '0;
            cm_addr <= '0;
        end else begin
            cm_vld  <= |strb;
            cm_mask <= strb;
            if (|strb) begin
                cm_addr <= bus.cradr;
            end
        end
    end

    // Commit: only masked slices and their parity bits are written. A RESET in the commit
    // cycle drops the pending write so storage stays as it was.
    always_ff @(posedge clk) begin
        if (!RESET && cm_vld) begin
            for (int s = 0; s < SLICES; s++) begin
                if (cm_mask[s]) begin
                    mem_data[cm_addr][s*SW +: SW] <= stage_data[s*SW +: SW];
                    mem_par[cm_addr][s]           <= stage_par[s];
                end
            end
        end
    end

    // Read mux with write-first bypass: a commit to the address being read this cycle
    // supplies the new slices and their parity, so the checker sees the bypassed word.
    always_comb begin
        rd_data = mem_data[bus.cradr];
        rd_par  = mem_par[bus.cradr];
        if (cm_vld && (cm_addr == bus.cradr)) begin
            for (int s = 0; s < SLICES; s++) begin
                if (cm_mask[s]) begin
                    rd_data[s*SW +: SW] = stage_data[s*SW +: SW];
                    rd_par[s]           = stage_par[s];
                end
            end
        end
    end

    // Microword register. The parity of the loaded word travels with it so the check can
    // run one edge later. chk_en masks the first check after reset, which would otherwise
    // examine the zeroed register (zero data with zero parity looks like four errors).
    always_ff @(posedge clk) begin
        if (RESET) begin
            cram_q   <= '0;
            cram_par <= '0;
            chk_en   <= 1'b0;
        end else begin
            cram_q   <= rd_data;
            cram_par <= rd_par;
            chk_en   <= 1'b1;
        end
    end

    // Per-slice odd-parity check of the currently held word; a fresh error beats par_clr.
    always_comb begin
        err_vec = '0;
        for (int s = 0; s < SLICES; s++) begin
            err_vec[s] = chk_en && (cram_par[s] != ~^cram_q[s*SW +: SW]);
        end
        err_nxt = (bus.par_clr ? 4'b0000 : err_q) | err_vec;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            err_q <= '0;
        end else begin
            err_q <= err_nxt;
        end
    end

    assign bus.cram          = cram_q;
    assign bus.busy          = cm_vld;
    assign bus.par_err       = |err_q;
    assign bus.par_err_slice = err_q;
endmodule

// File: tb/tb_cram_store.sv
// Directed bench for cram_store: reset state, read latency, slice/multi-strobe/pipelined
// writes, write-first bypass, sticky parity error with clear priority, reset during commit.
module tb_cram_store;
    logic clk;
    logic reset;
    int   passes;
    int   checks;
    logic [0:79] acc;

    cram_store_if bus ();

    cram_store dut (
        .clk   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk80(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic strobes(input logic [3:0] m, input logic [19:0] d);
        bus.wr_00_19  = m[3];
        bus.wr_20_39  = m[2];
        bus.wr_40_59  = m[1];
        bus.wr_60_79  = m[0];
        bus.ebus_data = d;
    endtask

    initial begin
        passes = 0;
        checks = 0;
        reset  = 1'b1;
        bus.cradr   = '0;
        bus.par_clr = 1'b0;
        strobes(4'b0000, 20'h0);

        // Reset state
        step();
        step();
        chk80("rst_cram", bus.cram, 80'h0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_par_err", bus.par_err, 1'b0);
        chk4("rst_par_slice", bus.par_err_slice, 4'b0000);

        // Read latency after init
        reset = 1'b0;
        bus.cradr = 11'h123;
        step();
        chk80("rd_123", bus.cram, 80'h0);
        chk1("rd_123_perr", bus.par_err, 1'b0);

        // Sweep of all 2048 addresses: zero data, no parity errors
        acc = '0;
        for (int a = 0; a < 2048; a++) begin
            bus.cradr = 11'(a);
            step();
            acc = acc | bus.cram;
        end
        step();
        chk80("sweep_data", acc, 80'h0);
        chk1("sweep_perr", bus.par_err, 1'b0);
        chk4("sweep_slice", bus.par_err_slice, 4'b0000);

        // Single slice write 20:39 at 0x7FF
        bus.cradr = 11'h7FF;
        strobes(4'b0100, 20'hABCDE);
        step();
        strobes(4'b0000, 20'h0);
        chk1("slice_busy", bus.busy, 1'b1);
        bus.cradr = 11'h000;
        step();
        chk1("slice_busy_done", bus.busy, 1'b0);
        bus.cradr = 11'h7FF;
        step();
        chk80("slice_rd_7ff", bus.cram, 80'h00000_ABCDE_00000_00000);
        step();
        chk1("slice_perr", bus.par_err, 1'b0);

        // Multi-strobe at 0x001 then pipelined slice 0 write at 0x002
        bus.cradr = 11'h001;
        strobes(4'b1111, 20'h00001);
        step();
        chk1("pipe_busy_a", bus.busy, 1'b1);
        bus.cradr = 11'h002;
        strobes(4'b1000, 20'hFFFFF);
        step();
        chk1("pipe_busy_b", bus.busy, 1'b1);
        strobes(4'b0000, 20'h0);
        bus.cradr = 11'h003;
        step();
        chk1("pipe_busy_c", bus.busy, 1'b0);
        bus.cradr = 11'h001;
        step();
        chk80("pipe_rd_001", bus.cram, 80'h00001_00001_00001_00001);
        bus.cradr = 11'h002;
        step();
        chk80("pipe_rd_002", bus.cram, 80'hFFFFF_00000_00000_00000);
        step();
        chk1("pipe_perr", bus.par_err, 1'b0);

        // Write-first bypass at 0x040
        bus.cradr = 11'h040;
        strobes(4'b0010, 20'h12345);
        step();
        chk80("byp_old", bus.cram, 80'h0);
        strobes(4'b0000, 20'h0);
        step();
        chk80("byp_new", bus.cram, 80'h00000_00000_12345_00000);
        bus.cradr = 11'h000;
        step();
        chk1("byp_perr", bus.par_err, 1'b0);

        // Parity error on slice 2 at 0x010
        dut.mem_par[11'h010] = 4'b1101;
        bus.cradr = 11'h010;
        step();
        chk1("perr_not_yet", bus.par_err, 1'b0);
        bus.cradr = 11'h011;
        step();
        chk1("perr_set", bus.par_err, 1'b1);
        chk4("perr_slice", bus.par_err_slice, 4'b0010);
        step();
        chk1("perr_sticky", bus.par_err, 1'b1);
        chk4("perr_slice_sticky", bus.par_err_slice, 4'b0010);
        bus.par_clr = 1'b1;
        step();
        bus.par_clr = 1'b0;
        chk1("perr_clr", bus.par_err, 1'b0);
        chk4("perr_clr_slice", bus.par_err_slice, 4'b0000);

        // A new error in the same cycle as par_clr wins
        bus.cradr = 11'h010;
        step();
        bus.cradr = 11'h011;
        bus.par_clr = 1'b1;
        step();
        bus.par_clr = 1'b0;
        chk1("perr_set_wins", bus.par_err, 1'b1);
        chk4("perr_set_wins_slice", bus.par_err_slice, 4'b0010);

        // Reset mid-write at 0x100; strobes during reset are ignored
        bus.cradr = 11'h100;
        strobes(4'b0001, 20'hFFFFF);
        step();
        reset = 1'b1;
        strobes(4'b1000, 20'h55555);
        step();
        strobes(4'b0000, 20'h0);
        chk80("mid_rst_cram", bus.cram, 80'h0);
        chk1("mid_rst_busy", bus.busy, 1'b0);
        chk1("mid_rst_perr", bus.par_err, 1'b0);
        chk4("mid_rst_slice", bus.par_err_slice, 4'b0000);
        reset = 1'b0;
        step();
        chk80("mid_rst_rd_100", bus.cram, 80'h0);
        chk1("mid_rst_busy_after", bus.busy, 1'b0);
        step();
        chk1("mid_rst_perr_after", bus.par_err, 1'b0);
        step();
        chk80("mid_rst_rd_100_again", bus.cram, 80'h0);
        chk1("mid_rst_perr_final", bus.par_err, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/cram_store.md
CRAM_STORE -- requirements
Module: cram_store

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL have port `clk`: input, 1 bit. The CRA microcode clock; all state updates on its rising edge.
REQ-003 SHALL have port `RESET`: input, 1 bit. Synchronous, active-high master reset.
REQ-004 SHALL have port `cradr`: input, 11 bits [0:10]. Next CRAM address, as produced by the CRA address logic.
REQ-005 SHALL have port `ebus_data`: input, 20 bits [0:19]. Diagnostic write data, taken from EBUS bits 0:19.
REQ-006 SHALL have ports `wr_00_19`, `wr_20_39`, `wr_40_59`, `wr_60_79`: inputs, 1 bit each. Diagnostic slice-write strobes, each 1-cycle pulse.
REQ-007 SHALL have port `par_clr`: input, 1 bit. Clears the sticky parity-error state.
REQ-008 SHALL have port `cram`: output, 80 bits [0:79]. Registered microinstruction word.
REQ-009 SHALL have port `busy`: output, 1 bit. A diagnostic commit is in progress this cycle.
REQ-010 SHALL have port `par_err`: output, 1 bit. Sticky CRAM parity error.
REQ-011 SHALL have port `par_err_slice`: output, 4 bits [0:3]. Sticky per-slice error flags: bit 0 = 00_19 … bit 3 = 60_79.

Function
REQ-012 SHALL hold storage of 2048 words, each 80 data bits plus 4 parity bits (one per 20-bit slice).
REQ-013 SHALL keep each stored parity bit odd: the bit equals the inverse of the XOR of its 20-bit slice.
REQ-014 SHALL initialise, at time zero, every word to data 0 with parity 4'b1111.
REQ-015 SHALL not alter storage on RESET.
REQ-016 SHALL register reads with 1-cycle latency: `cram` loads mem[`cradr`] on every rising edge when RESET=0.
REQ-017 SHALL perform diagnostic writes in two cycles:
- Capture cycle N: with any strobe high, store `ebus_data` into each strobed slice of the staging word; latch `cradr` and the strobe mask.
- Commit cycle N+1: write only the masked slices and their parity bits to mem[latched address]; `busy`=1.
REQ-018 SHALL, when multiple strobes are high in the same cycle, write all strobed slices with the same `ebus_data`.
REQ-019 SHALL pipeline back-to-back strobes: a capture in cycle N+1 commits in N+2 with no loss, and `busy` stays 1.
REQ-020 SHALL resolve a read and commit to the same address in the same cycle as write-first: `cram` receives the new slice values.
REQ-021 SHALL check parity at every `cram` load after the first post-reset load. For each slice where the stored parity is not the inverse of the XOR of the slice data, it SHALL set that `par_err_slice` bit and `par_err`, one cycle after the load.
REQ-022 SHALL keep `par_err` and `par_err_slice` set until `par_clr` or RESET.
REQ-023 SHALL clear the error state on `par_clr`=1; a new error detected in the same cycle wins (set takes priority).
REQ-024 SHALL compute parity over the write-first bypassed data when that bypass is in effect (REQ-020).
REQ-025 SHALL make `cradr` wrap-free: all 2048 addresses are valid and there is no out-of-range case.

Reset
REQ-026 SHALL, with RESET=1 at an edge, set `cram`=0, `busy`=0, `par_err`=0 and `par_err_slice`=0.
REQ-027 SHALL, on RESET, discard any pending commit: a capture in cycle N followed by RESET in N+1 leaves storage unchanged.
REQ-028 SHALL, on RESET, suppress the parity check for the first load after reset, since the register held 0.
REQ-029 SHALL ignore strobes while RESET=1.

Verification
REQ-030 SHALL cover read latency: after init, `cradr`=0x123 → next cycle `cram`=0 and `par_err`=0; for 2048 sequential addresses, no error flags.
REQ-031 SHALL cover slice write: `cradr`=0x7FF with `wr_20_39`, data 0xABCDE → `busy`=1 the next cycle; a read of 0x7FF then gives `cram`[20:39]=0xABCDE and all other bits 0.
REQ-032 SHALL cover multi-strobe and pipelined writes: all four strobes, data 0x00001, at 0x001, then `wr_00_19`, data 0xFFFFF, at 0x002 in the next cycle → 0x001 reads 0x00001 in every slice and 0x002 reads 0xFFFFF in [0:19]; `busy` is high for 2 cycles.
REQ-033 SHALL cover bypass: a commit to 0x040 in the same cycle as `cradr`=0x040 → `cram` shows the new data immediately and no parity error.
REQ-034 SHALL cover the parity error: force the parity bit of slice 2 at 0x010 → read 0x010 sets `par_err`=1 and `par_err_slice`=4'b0010 (bit 2 set); both stay set after a good read; `par_clr` → 0 on the next cycle.
REQ-035 SHALL cover reset mid-write: a capture at 0x100 followed by RESET in the next cycle → mem[0x100] unchanged, and all outputs 0.
